// File: rtl/io_output_pkg.sv
// Shared definitions for the memory-mapped output port bank: register offsets
// relative to the end of the port window, reset defaults and the word decoder.
package io_output_pkg;

  // Control words follow the port window, offsets counted from BASE_WORD + N_PORTS.
  localparam int unsigned MODE_OFS     = 0;
  localparam int unsigned PLEN_OFS     = 1;
  localparam int unsigned STATUS_OFS   = 2;

  // A pulse always lasts at least one cycle, so the reset pulse length is 1.
  localparam int unsigned DEFAULT_PLEN = 1;

  // Only addr[7:2] is decoded; up to 8 channels need a 3-bit port index.
  localparam int unsigned WORD_W       = 6;
  localparam int unsigned PORT_IDX_W   = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PORT,
    SEL_MODE,
    SEL_PLEN,
    SEL_STATUS
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e                kind;
    logic [PORT_IDX_W-1:0]   port;
  } reg_dec_t;

  // Map a word index onto the register it selects; anything outside the
  // window decodes to SEL_NONE (writes ignored, reads return zero).
  function automatic reg_dec_t decode_word(input logic [WORD_W-1:0] word,
                                           input int unsigned        base,
                                           input int unsigned        n_ports);
    reg_dec_t dec;
    int       off;
    dec.kind = SEL_NONE;
    dec.port = '0;
    off      = int'({26'd0, word}) - int'(base);
    if (off >= 0 && off < int'(n_ports)) begin
      dec.kind = SEL_PORT;
      dec.port = PORT_IDX_W'(off);
    end else if (off == int'(n_ports + MODE_OFS)) begin
      dec.kind = SEL_MODE;
    end else if (off == int'(n_ports + PLEN_OFS)) begin
      dec.kind = SEL_PLEN;
    end else if (off == int'(n_ports + STATUS_OFS)) begin
      dec.kind = SEL_STATUS;
    end
    return dec;
  endfunction

endpackage

// File: rtl/io_out_channel.sv
// One output channel: a WIDTH-bit value register plus a pulse-length counter.
// In level mode a write simply loads the value; in pulse mode the value is
// held for max(plen,1) cycles and then cleared. busy_o flags a live pulse.
module io_out_channel
  import io_output_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PULSE_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_i,      // store to this channel's port word
  input  logic               mode_i,    // 1 = pulse, 0 = level (current MODE bit)
  input  logic               cancel_i,  // MODE write clearing this channel's bit
  input  logic [PULSE_W-1:0] plen_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic [WIDTH-1:0]   value_o,
  output logic               busy_o
);

  logic [WIDTH-1:0]   value_q, value_d;
  logic [PULSE_W-1:0] cnt_q,   cnt_d;

  // Next-state: a write wins over cancel, cancel wins over the countdown.
  always_comb begin
    // NOTE: every variable gets a default before the branches, so no path
    // leaves it unassigned and no latch is inferred.
    value_d = value_q;
    cnt_d   = cnt_q;
    if (wr_i) begin
      value_d = data_i;
      if (mode_i) begin
        cnt_d = (plen_i == '0) ? PULSE_W'(DEFAULT_PLEN) : plen_i;
      end else begin
        cnt_d = '0;
      end
    end else if (cancel_i) begin
      // Channel falls back to level mode: stop counting, keep the value.
      cnt_d = '0;
    end else if (cnt_q == PULSE_W'(1)) begin
      cnt_d   = '0;
      value_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PULSE_W'(1);
    end
  end

  // State register with immediate clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_ni) begin
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value_o = value_q;
  assign busy_o  = (cnt_q != '0);

endmodule

// File: rtl/io_output_bank.sv
// Memory-mapped output port bank on the CPU I/O space. Decodes addr[7:2],
// holds the MODE and PLEN control registers, steers stores to the channels
// and provides combinational readback of every register.
module io_output_bank
  import io_output_pkg::*;
#(
  parameter int unsigned N_PORTS   = 3,
  parameter int unsigned WIDTH     = 32,
  parameter logic [5:0]  BASE_WORD = 6'b100000,
  parameter int unsigned PULSE_W   = 16
) (
  input  logic                       io_clk,
  input  logic                       resetn,
  input  logic [31:0]                addr,
  input  logic [31:0]                datain,
  input  logic                       write_io_enable,
  output logic [31:0]                dataout,
  output logic [N_PORTS*WIDTH-1:0]   out_ports,
  output logic [N_PORTS-1:0]         busy
);

  reg_dec_t           dec;
  logic [N_PORTS-1:0] mode_q, mode_d;
  logic [PULSE_W-1:0] plen_q, plen_d;
  logic [N_PORTS-1:0] port_wr;
  logic [N_PORTS-1:0] mode_cancel;

  // Only the word index is decoded; the remaining address bits are ignored.
  logic unused_addr;
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  assign dec = decode_word(addr[7:2], 32'(BASE_WORD), N_PORTS);

  // Control register next-state: MODE and PLEN load on their own word.
  always_comb begin
    mode_d = mode_q;
    plen_d = plen_q;
    if (write_io_enable) begin
      case (dec.kind)
        SEL_MODE: mode_d = datain[N_PORTS-1:0];
        SEL_PLEN: plen_d = datain[PULSE_W-1:0];
        default:  ;
      endcase
    end
  end

  // Control registers; PLEN comes out of reset at the minimum pulse length.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      mode_q <= '0;
      plen_q <= PULSE_W'(DEFAULT_PLEN);
    end else begin
      mode_q <= mode_d;
      plen_q <= plen_d;
    end
  end

  // One channel per port; each sees its own write strobe and MODE bit.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_chan
    assign port_wr[i]     = write_io_enable && (dec.kind == SEL_PORT) &&
                            (dec.port == PORT_IDX_W'(i));
    assign mode_cancel[i] = write_io_enable && (dec.kind == SEL_MODE) && !datain[i];

    io_out_channel #(
      .WIDTH   (WIDTH),
      .PULSE_W (PULSE_W)
    ) u_chan (
      .clk_i    (io_clk),
      .rst_ni   (resetn),
      .wr_i     (port_wr[i]),
      .mode_i   (mode_q[i]),
      .cancel_i (mode_cancel[i]),
      .plen_i   (plen_q),
      .data_i   (datain[WIDTH-1:0]),
      .value_o  (out_ports[i*WIDTH +: WIDTH]),
      .busy_o   (busy[i])
    );
  end

  // Combinational readback, zero-extended; unmapped words read as zero.
  always_comb begin
    dataout = '0;
    case (dec.kind)
      SEL_PORT: begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
          if (dec.port == PORT_IDX_W'(i)) begin
            dataout = 32'(out_ports[i*WIDTH +: WIDTH]);
          end
        end
      end
      SEL_MODE:   dataout = 32'(mode_q);
      SEL_PLEN:   dataout = 32'(plen_q);
      SEL_STATUS: dataout = 32'(busy);
      default:    dataout = '0;
    endcase
  end

endmodule

// File: tb/tb_io_output_bank.sv
// Directed bench for io_output_bank with default parameters
// (3 ports x 32 bits; ports at 0x80/0x84/0x88, MODE 0x8C, PLEN 0x90, STATUS 0x94).
module tb_io_output_bank;

  logic        io_clk;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        write_io_enable;
  logic [31:0] dataout;
  logic [95:0] out_ports;
  logic [2:0]  busy;

  int n_assert = 0;
  int n_fail   = 0;

  io_output_bank dut (
    .io_clk          (io_clk),
    .resetn          (resetn),
    .addr            (addr),
    .datain          (datain),
    .write_io_enable (write_io_enable),
    .dataout         (dataout),
    .out_ports       (out_ports),
    .busy            (busy)
  );

  initial begin
    io_clk = 1'b0;
    forever #5 io_clk = ~io_clk;
  end

  function automatic logic [95:0] ports(input logic [31:0] p2, input logic [31:0] p1,
                                        input logic [31:0] p0);
    return {p2, p1, p0};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: store is sampled on the next rising edge,
  // returns at the following falling edge with write_io_enable dropped.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr            = a;
    datain          = d;
    write_io_enable = 1'b1;
    @(negedge io_clk);
    write_io_enable = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, 96'(dataout), 96'(exp));
  endtask

  initial begin
    addr            = 32'h0;
    datain          = 32'h0;
    write_io_enable = 1'b0;
    resetn          = 1'b1;
    #3 resetn = 1'b0;
    #1;
    check("reset_ports", out_ports, 96'h0);
    check("reset_busy", 96'(busy), 96'h0);
    rd("reset_mode", 32'h8C, 32'h0);
    rd("reset_plen", 32'h90, 32'h1);
    rd("reset_status", 32'h94, 32'h0);
    repeat (2) @(negedge io_clk);
    resetn = 1'b1;

    // Level-mode write to port 0, held for 100 cycles.
    wr(32'h80, 32'h0000_00A5);
    check("lvl_port0", out_ports, ports(0, 0, 32'hA5));
    check("lvl_busy", 96'(busy), 96'h0);
    repeat (100) @(negedge io_clk);
    check("lvl_hold100", out_ports, ports(0, 0, 32'hA5));
    check("lvl_busy100", 96'(busy), 96'h0);
    rd("lvl_read", 32'h80, 32'hA5);

    // PLEN=4, port 1 in pulse mode: high for exactly 4 edges.
    wr(32'h90, 32'd4);
    wr(32'h8C, 32'b010);
    rd("plen_read4", 32'h90, 32'd4);
    rd("mode_read2", 32'h8C, 32'h2);
    wr(32'h84, 32'h1234);
    check("pulse_c1", out_ports, ports(0, 32'h1234, 32'hA5));
    check("pulse_busy_c1", 96'(busy), 96'h2);
    rd("pulse_read", 32'h84, 32'h1234);
    for (int j = 2; j <= 4; j++) begin
      @(negedge io_clk);
      check($sformatf("pulse_c%0d", j), out_ports, ports(0, 32'h1234, 32'hA5));
      check($sformatf("pulse_busy_c%0d", j), 96'(busy), 96'h2);
    end
    @(negedge io_clk);
    check("pulse_end", out_ports, ports(0, 0, 32'hA5));
    check("pulse_end_busy", 96'(busy), 96'h0);

    // Rewrite on the 3rd pulse cycle restarts a full 4-cycle pulse.
    wr(32'h84, 32'h1234);
    @(negedge io_clk);
    check("rew_before", out_ports, ports(0, 32'h1234, 32'hA5));
    wr(32'h84, 32'h5678);
    check("rew_c1", out_ports, ports(0, 32'h5678, 32'hA5));
    for (int j = 2; j <= 4; j++) begin
      @(negedge io_clk);
      check($sformatf("rew_c%0d", j), out_ports, ports(0, 32'h5678, 32'hA5));
      check($sformatf("rew_busy_c%0d", j), 96'(busy), 96'h2);
    end
    @(negedge io_clk);
    check("rew_end", out_ports, ports(0, 0, 32'hA5));
    check("rew_end_busy", 96'(busy), 96'h0);

    // PLEN=0 behaves as a 1-cycle pulse; STATUS shows the live channel.
    wr(32'h90, 32'd0);
    rd("plen_read0", 32'h90, 32'h0);
    wr(32'h84, 32'hBEEF);
    check("p0_c1", out_ports, ports(0, 32'hBEEF, 32'hA5));
    rd("p0_status", 32'h94, 32'h2);
    @(negedge io_clk);
    check("p0_end", out_ports, ports(0, 0, 32'hA5));
    check("p0_end_busy", 96'(busy), 96'h0);
    rd("p0_status_end", 32'h94, 32'h0);

    // Clearing the MODE bit mid-pulse turns the channel into a held level.
    wr(32'h90, 32'd5);
    wr(32'h84, 32'hCAFE);
    check("cancel_busy_on", 96'(busy), 96'h2);
    @(negedge io_clk);
    wr(32'h8C, 32'h0);
    check("cancel_busy_off", 96'(busy), 96'h0);
    check("cancel_held", out_ports, ports(0, 32'hCAFE, 32'hA5));
    repeat (10) @(negedge io_clk);
    check("cancel_held10", out_ports, ports(0, 32'hCAFE, 32'hA5));

    // Level write to port 2, then setting MODE bits on idle channels.
    wr(32'h88, 32'h0F0F);
    check("lvl_port2", out_ports, ports(32'h0F0F, 32'hCAFE, 32'hA5));
    wr(32'h8C, 32'b101);
    check("mode_set_idle", out_ports, ports(32'h0F0F, 32'hCAFE, 32'hA5));
    check("mode_set_busy", 96'(busy), 96'h0);
    rd("mode_read5", 32'h8C, 32'h5);

    // Asynchronous reset in the middle of a pulse.
    wr(32'h8C, 32'b010);
    wr(32'h84, 32'h77);
    check("pre_rst", out_ports, ports(32'h0F0F, 32'h77, 32'hA5));
    check("pre_rst_busy", 96'(busy), 96'h2);
    #2 resetn = 1'b0;
    #1;
    check("rst_ports", out_ports, 96'h0);
    check("rst_busy", 96'(busy), 96'h0);
    rd("rst_mode", 32'h8C, 32'h0);
    rd("rst_plen", 32'h90, 32'h1);
    @(negedge io_clk);
    resetn = 1'b1;

    // Unmapped word: write ignored, reads zero.
    wr(32'hFC, 32'hFFFF_FFFF);
    check("unmap_ports", out_ports, 96'h0);
    check("unmap_busy", 96'(busy), 96'h0);
    rd("unmap_read", 32'hFC, 32'h0);
    rd("unmap_mode", 32'h8C, 32'h0);
    rd("unmap_plen", 32'h90, 32'h1);

    // Default PLEN after reset gives a 1-cycle pulse on port 0.
    wr(32'h8C, 32'b001);
    wr(32'h80, 32'h3C);
    check("dflt_c1", out_ports, ports(0, 0, 32'h3C));
    check("dflt_busy", 96'(busy), 96'h1);
    @(negedge io_clk);
    check("dflt_end", out_ports, 96'h0);
    check("dflt_end_busy", 96'(busy), 96'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
